// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the two-port data memory arbiter.
// Holds the port ids, request bundle and lock FSM states.
package dmem_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int ARB_N_PORTS = 2;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_DBG  = 1'b1
    } arb_port_e;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_st_e;

    typedef struct packed {
        logic            wen;
        logic            lock;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wmask;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response and data_mem signals of the arbiter, flattened per port.
// master = requesters plus memory model, slave = the arbiter itself.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_AWIDTH = 10
);
    logic [ARB_N_PORTS-1:0]      req_valid;
    logic [ARB_N_PORTS-1:0]      req_ready;
    logic [ARB_N_PORTS-1:0]      req_wen;
    logic [ARB_N_PORTS-1:0]      req_lock;
    logic [ARB_N_PORTS*XLEN-1:0] req_addr;
    logic [ARB_N_PORTS*XLEN-1:0] req_wdata;
    logic [ARB_N_PORTS*4-1:0]    req_wmask;
    logic [ARB_N_PORTS-1:0]      rsp_valid;
    logic [XLEN-1:0]             rsp_rdata;
    logic                        rsp_err;
    logic [MEM_AWIDTH-1:0]       mem_addr;
    logic [XLEN-1:0]             mem_wdata;
    logic [3:0]                  mem_wmask;
    logic                        mem_wen;
    logic [XLEN-1:0]             mem_rdata;

    modport master (
        output req_valid, req_wen, req_lock, req_addr, req_wdata, req_wmask, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_wmask, mem_wen
    );

    modport slave (
        input  req_valid, req_wen, req_lock, req_addr, req_wdata, req_wmask, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_wmask, mem_wen
    );
endinterface

// File: rtl/dmem_arbiter_arb_pick2.sv
// Two-way winner select: active lock owner, else sole valid port, else tie preference.
// Latency: combinational.
// Backpressure: grant only for a valid winner; the loser simply sees no grant.
module arb_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       lock_vld,
    input  arb_port_e  lock_owner,
    input  arb_port_e  pref,
    output arb_port_e  winner,
    output logic [1:0] grant
);

    always_comb begin
        winner = ARB_CORE;
        if (lock_vld) begin
            winner = lock_owner;
        end else if (valid == 2'b10) begin
            winner = ARB_DBG;
        end else if (valid == 2'b11) begin
            winner = pref;
        end
        grant         = 2'b00;
        grant[winner] = valid[winner];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_mem between core (port 0) and debug/loader (port 1); DMEM_ARB_RR_EN selects round-robin ties.
// Latency: one access per cycle, response registered one cycle after accept.
// Backpressure: req_ready only to the winner; a locked owner stalls the other port up to MAX_LOCK beats.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_AWIDTH = 10,
    parameter int MAX_LOCK   = 16
)(
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    dmem_req_t        req [ARB_N_PORTS];
    dmem_req_t        sel;
    lock_st_e         state_q, state_d;
    logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [CW:0]      cnt_inc;
    logic             force_q, force_d;
    arb_port_e        force_port_q, force_port_d;
    arb_port_e        rr_ptr, pref, winner, lock_owner;
    logic             lock_vld, accept, in_range;
    logic [1:0]       grant;
    logic [1:0]       rsp_valid_q;
    logic [XLEN-1:0]  rsp_rdata_q;
    logic             rsp_err_q;

    always_comb begin
        for (int i = 0; i < ARB_N_PORTS; i++) begin
            req[i].wen   = bus.req_wen[i];
            req[i].lock  = bus.req_lock[i];
            req[i].addr  = bus.req_addr[i*XLEN +: XLEN];
            req[i].wdata = bus.req_wdata[i*XLEN +: XLEN];
            req[i].wmask = bus.req_wmask[i*4 +: 4];
        end
    end

    assign lock_owner = (state_q == LOCKED1) ? ARB_DBG : ARB_CORE;
    assign lock_vld   = ((state_q == LOCKED0) && bus.req_valid[0]) ||
                        ((state_q == LOCKED1) && bus.req_valid[1]);
    // A watchdog release gives the very next tie to the port that was starved.
    assign pref       = force_q ? force_port_q : rr_ptr;

    arb_pick2 u_pick (
        .valid      (bus.req_valid),
        .lock_vld   (lock_vld),
        .lock_owner (lock_owner),
        .pref       (pref),
        .winner     (winner),
        .grant      (grant)
    );

    assign sel      = req[winner];
    assign accept   = (|grant) && !rst;
    assign in_range = (sel.addr[XLEN-1:MEM_AWIDTH] == '0);

    assign bus.req_ready = rst ? 2'b00 : grant;
    assign bus.mem_addr  = sel.addr[MEM_AWIDTH-1:0];
    assign bus.mem_wdata = sel.wdata;
    assign bus.mem_wmask = sel.wmask;
    assign bus.mem_wen   = accept && sel.wen && in_range;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign cnt_inc = {1'b0, lock_cnt_q} + 1'b1;

    always_comb begin
        state_d      = UNLOCKED;
        lock_cnt_d   = '0;
        force_d      = 1'b0;
        force_port_d = force_port_q;
        if (lock_vld) begin
            if (sel.lock && (cnt_inc < (CW+1)'(MAX_LOCK))) begin
                state_d    = state_q;
                lock_cnt_d = cnt_inc[CW-1:0];
            end else if (sel.lock) begin
                force_d      = 1'b1;
                force_port_d = arb_port_e'(~lock_owner);
            end
        end else if (accept && sel.lock) begin
            // Either a fresh lock, or the other port taking over after the owner dropped valid.
            state_d    = (winner == ARB_DBG) ? LOCKED1 : LOCKED0;
            lock_cnt_d = CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNLOCKED;
            lock_cnt_q   <= '0;
            force_q      <= 1'b0;
            force_port_q <= ARB_CORE;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            force_q      <= force_d;
            force_port_q <= force_port_d;
            rsp_valid_q  <= accept ? grant : 2'b00;
            rsp_rdata_q  <= (accept && in_range && !sel.wen) ? bus.mem_rdata : '0;
            rsp_err_q    <= accept && !in_range;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= ARB_CORE;
        end else if (accept) begin
            rr_ptr <= arb_port_e'(~winner);
        end
    end
`else
    assign rr_ptr = ARB_CORE;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-masked data_mem model (combinational read).
// Define DMEM_ARB_RR_EN for both bench and RTL to check the round-robin build.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] mem [0:255];

    dmem_arbiter_if #(.MEM_AWIDTH(10)) bus ();

    dmem_arbiter #(.MEM_AWIDTH(10), .MAX_LOCK(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (bus.mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wmask[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic w, input logic l,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.req_valid[p]         = v;
        bus.req_wen[p]           = w;
        bus.req_lock[p]          = l;
        bus.req_addr[p*32 +: 32]  = a;
        bus.req_wdata[p*32 +: 32] = d;
        bus.req_wmask[p*4 +: 4]   = m;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    logic [1:0] exp_rdy;

    initial begin
        rst = 1'b1;
        idle();
        tick();
        // Reset: outputs quiet, no ready or write even with requests present.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1, 4'hF);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        #1;
        chk("rst_ready", {30'h0, bus.req_ready}, 32'h0);
        chk("rst_wen", {31'h0, bus.mem_wen}, 32'h0);
        tick();
        chk("rst_rsp_valid", {30'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_err", {31'h0, bus.rsp_err}, 32'h0);
        idle();
        rst = 1'b0;
        tick();

        // Tie: both load every cycle for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
            drive(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
`ifdef DMEM_ARB_RR_EN
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_rdy = 2'b01;
`endif
            #1;
            chk($sformatf("tie_ready_%0d", i), {30'h0, bus.req_ready}, {30'h0, exp_rdy});
            tick();
            chk($sformatf("tie_rsp_%0d", i), {30'h0, bus.rsp_valid}, {30'h0, exp_rdy});
        end
        idle();
        tick();

        // Store then load same address, then a partial-mask store.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        #1;
        chk("st_ready", {30'h0, bus.req_ready}, 32'h1);
        chk("st_wen", {31'h0, bus.mem_wen}, 32'h1);
        chk("st_addr", {22'h0, bus.mem_addr}, 32'h10);
        tick();
        chk("st_rsp", {30'h0, bus.rsp_valid}, 32'h1);
        chk("st_rdata", bus.rsp_rdata, 32'h0);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        chk("ld_ready", {30'h0, bus.req_ready}, 32'h1);
        chk("ld_wen", {31'h0, bus.mem_wen}, 32'h0);
        tick();
        chk("ld_rsp", {30'h0, bus.rsp_valid}, 32'h1);
        chk("ld_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("ld_err", {31'h0, bus.rsp_err}, 32'h0);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h11223344, 4'b0011);
        #1;
        chk("pm_wmask", {28'h0, bus.mem_wmask}, 32'h3);
        tick();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        chk("pm_rdata", bus.rsp_rdata, 32'hDEAD3344);
        idle();
        tick();

        // Lock burst: port1 stores lock=1,1,0 then one more unlocked store, port0 valid from beat 2.
        for (int b = 0; b < 4; b++) begin
            drive(1, 1'b1, 1'b1, (b < 2), 32'h40 + 32'(b*4), 32'hA0 + 32'(b), 4'hF);
            if (b > 0) drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
            exp_rdy = (b < 3) ? 2'b10 : 2'b01;
            #1;
            chk($sformatf("burst_ready_%0d", b), {30'h0, bus.req_ready}, {30'h0, exp_rdy});
            tick();
        end
        idle();
        tick();

        // Watchdog: port1 holds lock for up to 17 beats, port0 valid from beat 2.
        for (int b = 1; b <= 17; b++) begin
            drive(1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF);
            if (b > 1) drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
            exp_rdy = (b <= 16) ? 2'b10 : 2'b01;
            #1;
            chk($sformatf("wdog_ready_%0d", b), {30'h0, bus.req_ready}, {30'h0, exp_rdy});
            tick();
        end
        idle();
        tick();

        // Out of range: seed address 0, store to 0x400, check memory unchanged, OOR load.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h12345678, 4'hF);
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h55AA55AA, 4'hF);
        #1;
        chk("oor_ready", {30'h0, bus.req_ready}, 32'h1);
        chk("oor_wen", {31'h0, bus.mem_wen}, 32'h0);
        tick();
        chk("oor_rsp", {30'h0, bus.rsp_valid}, 32'h1);
        chk("oor_err", {31'h0, bus.rsp_err}, 32'h1);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        tick();
        chk("oor_mem_kept", bus.rsp_rdata, 32'h12345678);
        chk("oor_ok_err", {31'h0, bus.rsp_err}, 32'h0);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 4'hF);
        tick();
        chk("oor_ld_err", {31'h0, bus.rsp_err}, 32'h1);
        chk("oor_ld_rdata", bus.rsp_rdata, 32'h0);
        idle();
        tick();

        // Reset mid-burst.
        drive(1, 1'b1, 1'b1, 1'b1, 32'h60, 32'hBEEF, 4'hF);
        #1;
        chk("mrst_lock_ready", {30'h0, bus.req_ready}, 32'h2);
        tick();
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        chk("mrst_ready", {30'h0, bus.req_ready}, 32'h0);
        tick();
        chk("mrst_rsp", {30'h0, bus.rsp_valid}, 32'h0);
        rst = 1'b0;
        #1;
        chk("mrst_after_ready", {30'h0, bus.req_ready}, 32'h1);
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
